// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode packet type, the decode-side NOP filler and the
// default fetch-queue depth.
package fetch_queue_pkg;

    localparam int          FETCH_Q_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR     = 32'h00000013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } pipe_common;

    // Stored payload only; validity of an entry is implied by the pointers.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: DEPTH-entry circular buffer in program
// order, valid/ready on both sides, whole-queue drop on redirect flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_Q_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  pipe_common               if_in,
    output logic                     if_ready,
    output pipe_common               id_out,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("fetch_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fq_entry_t     mem_q [DEPTH];

    logic not_empty;
    logic enq;
    logic deq;

    assign not_empty = (cnt_q != '0);
    assign if_ready  = (cnt_q != CW'(DEPTH));
    assign occupancy = cnt_q;

    always_comb begin
        enq = if_in.valid && if_ready && !flush;
        deq = not_empty && id_ready && !flush;
    end

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (enq) wp_d = wp_q + 1'b1;
            if (deq) rp_d = rp_q + 1'b1;
            cnt_d = cnt_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset; pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wp_q] <= '{pc: if_in.pc, instr: if_in.instr};
        end
    end

    always_comb begin
        id_out.valid = not_empty;
        id_out.pc    = '0;
        id_out.instr = NOP_INSTR;
        if (not_empty) begin
            id_out.pc    = mem_q[rp_q].pc;
            id_out.instr = mem_q[rp_q].instr;
        end
    end

endmodule
